idx_step_reader: RTL and testbench
==================================

Name: idx_step_reader

Overview:
- Sequenced read engine for a 3-D integer table, addressed by one shared cursor `pos`.
- Each command gives one step operation per dimension (plain, post/pre increment, post/pre decrement). Steps are evaluated left to right (i, then j, then k), one dimension per cycle, with side effects on `pos`.
- Supports a short-circuit gate: lazy (logical) mode skips evaluation; eager (bitwise) mode keeps the side effects but zeroes the data.
- Sits downstream of the command/cursor source and feeds a valid/ready result consumer. Used as a regression vehicle for index side-effect ordering.

Parameters:
- `DI`, default 2, size of dimension i.
- `DJ`, default 3, size of dimension j.
- `DK`, default 4, size of dimension k.
- `DW`, default 32, element width.
- `PW`, default 8, cursor width; unsigned, wraps mod 2^PW.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_op_i`, `cmd_op_j`, `cmd_op_k`  in  3 each  0 plain, 1 pos++, 2 ++pos, 3 pos--, 4 --pos; 5-7 treated as plain.
- `cmd_gate`  in  1  0 = result forced to 0.
- `cmd_lazy`  in  1  1 = logical (skip evaluation when gate=0); 0 = bitwise.
- `pos_load`  in  1  load cursor.
- `pos_load_val`  in  PW  cursor load value.
- `wr_en`  in  1  table write strobe.
- `wr_addr`  in  clog2(DI*DJ*DK)  linear table address.
- `wr_data`  in  DW  table write data.
- `rd_valid`  out  1  result valid.
- `rd_ready`  in  1  consumer accepts result.
- `rd_data`  out  DW  element value.
- `rd_pos`  out  PW  cursor value after the command.
- `rd_err`  out  1  at least one index out of range.

Behaviour:
- Reset (`rst_n`=0, async): state=IDLE, pos=0, `rd_valid`=0, `rd_data`=0, `rd_pos`=0, `rd_err`=0. `cmd_ready`=1 once out of reset.
- Reset mid-operation aborts the command; no response is produced. Table contents are not affected by reset.
- Table: linear address = i*DJ*DK + j*DK + k. At time zero, entry n = n. Table read is synchronous and read-first: a write to the address being read in the same cycle returns the old data.
- `pos_load` is honoured only in IDLE. If `pos_load` and command accept occur in the same cycle, the load applies first and the command sees the loaded value. `pos_load` in any other state is ignored.
- A command is accepted on `cmd_valid && cmd_ready`; the next state is EVAL_I.
- Lazy skip: if `cmd_gate`=0 and `cmd_lazy`=1, go straight to OUT with `rd_data`=0, `rd_err`=0, `rd_pos`=pos unchanged. `rd_valid` rises 1 edge after accept.
- EVAL_I, EVAL_J, EVAL_K, one cycle each:
  - post ops: index = pos, then pos is updated.
  - pre ops: pos is updated, then index = new pos.
  - plain: index = pos, pos unchanged.
  - Arithmetic wraps mod 2^PW; decrementing 0 gives 2^PW-1.
- Range check: an index is out of range if it is >= its dimension size. Any out-of-range index sets err. Cursor side effects still apply in full.
- READ: issue the table read; skipped if err.
- OUT: `rd_valid`=1.
  - `rd_data` = err ? 0 : (gate ? element : 0).
  - `rd_pos` = final pos; `rd_err` = err.
  - `rd_valid` rises on the 4th edge after accept.
  - Outputs hold stable until `rd_ready`; on `rd_valid && rd_ready`, return to IDLE.
- Back-to-back: the earliest next accept is the cycle after the handshake.
- Writes are accepted in any state.

Test Plan:
- Load pos=0; ops (pos++, pos++, ++pos), gate=1 → `rd_data`=7, `rd_pos`=3, `rd_err`=0; `rd_valid` on the 4th edge after accept.
- Load pos=1; ops (pos--, ++pos, ++pos) → indices [1][1][2], `rd_data`=18, `rd_pos`=2.
- Load pos=0; ops all ++pos:
  - gate=0, lazy=1 → `rd_data`=0, `rd_pos`=0, `rd_valid` 1 edge after accept.
  - gate=0, lazy=0 → `rd_data`=0, `rd_pos`=3, `rd_err`=0.
- Load pos=0; ops (--pos, plain, plain) → `rd_err`=1, `rd_data`=0, `rd_pos`=255.
- Write addr 7 = 0xDEADBEEF, then repeat scenario 1 with `rd_ready`=0 for 3 cycles → `rd_data`=0xDEADBEEF held stable, `cmd_ready`=0 until the handshake.
- Assert `rst_n` low during EVAL_J → all outputs at reset values, pos=0, no `rd_valid`; the next command (scenario 1) returns 7 (or 0xDEADBEEF if the write persisted).

Source files
------------

// File: rtl/idx_step_reader_if.sv
// idx_step_reader_if: command, cursor-load, table-write and result channels of idx_step_reader
interface idx_step_reader_if #(
    parameter int DW = 32,
    parameter int PW = 8,
    parameter int AW = 5
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op_i;
    logic [2:0]    cmd_op_j;
    logic [2:0]    cmd_op_k;
    logic          cmd_gate;
    logic          cmd_lazy;
    logic          pos_load;
    logic [PW-1:0] pos_load_val;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [DW-1:0] rd_data;
    logic [PW-1:0] rd_pos;
    logic          rd_err;
    modport master (
        output cmd_valid, cmd_op_i, cmd_op_j, cmd_op_k, cmd_gate, cmd_lazy,
               pos_load, pos_load_val, wr_en, wr_addr, wr_data, rd_ready,
        input  cmd_ready, rd_valid, rd_data, rd_pos, rd_err
    );
    modport slave (
        input  cmd_valid, cmd_op_i, cmd_op_j, cmd_op_k, cmd_gate, cmd_lazy,
               pos_load, pos_load_val, wr_en, wr_addr, wr_data, rd_ready,
        output cmd_ready, rd_valid, rd_data, rd_pos, rd_err
    );
endinterface

// File: rtl/idx_step_reader.sv
// idx_step_reader: evaluates per-dimension cursor step ops (i, j, k in order) and reads one element
// of a 3-D table; lazy gating skips evaluation, eager gating keeps cursor side effects.
module idx_step_reader #(
    parameter int DI = 2,
    parameter int DJ = 3,
    parameter int DK = 4,
    parameter int DW = 32,
    parameter int PW = 8
) (
    input logic clk,
    input logic rst_n,
    idx_step_reader_if.slave bus
);
    localparam int N  = DI * DJ * DK;
    localparam int AW = $clog2(N);
    typedef enum logic [2:0] {IDLE, EVAL_I, EVAL_J, EVAL_K, READ, OUT} state_t;
    state_t        state_q;
    logic [PW-1:0] pos_q, pos_d, idx_d, dim;
    logic [PW-1:0] idx_i_q, idx_j_q, idx_k_q;
    logic [2:0]    op_i_q, op_j_q, op_k_q, op;
    logic          gate_q, lazy_q, err_q, oor;
    logic          rd_valid_q, rd_err_q;
    logic [DW-1:0] rd_data_q;
    logic [PW-1:0] rd_pos_q;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] tbl [N];
    // Table entries power up holding their own address and are never touched by reset.
    for (genvar g = 0; g < N; g++) begin : g_ent
        logic [DW-1:0] ent_q = DW'(g);
        always_ff @(posedge clk)
            if (bus.wr_en && bus.wr_addr == AW'(g)) ent_q <= bus.wr_data;
        assign tbl[g] = ent_q;
    end
    always_comb begin
        op      = state_q == EVAL_I ? op_i_q : state_q == EVAL_J ? op_j_q : op_k_q;
        dim     = state_q == EVAL_I ? PW'(DI) : state_q == EVAL_J ? PW'(DJ) : PW'(DK);
        pos_d   = (op == 3'd1 || op == 3'd2) ? pos_q + 1'b1 :
                  (op == 3'd3 || op == 3'd4) ? pos_q - 1'b1 : pos_q;
        idx_d   = (op == 3'd2 || op == 3'd4) ? pos_d : pos_q;
        oor     = idx_d >= dim;
        rd_addr = AW'(idx_i_q * DJ * DK + idx_j_q * DK + idx_k_q);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pos_q      <= '0;
            idx_i_q    <= '0;
            idx_j_q    <= '0;
            idx_k_q    <= '0;
            op_i_q     <= '0;
            op_j_q     <= '0;
            op_k_q     <= '0;
            gate_q     <= 1'b0;
            lazy_q     <= 1'b0;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_pos_q   <= '0;
            rd_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.pos_load) pos_q <= bus.pos_load_val;
                    if (bus.cmd_valid) begin
                        op_i_q  <= bus.cmd_op_i;
                        op_j_q  <= bus.cmd_op_j;
                        op_k_q  <= bus.cmd_op_k;
                        gate_q  <= bus.cmd_gate;
                        lazy_q  <= bus.cmd_lazy;
                        err_q   <= 1'b0;
                        state_q <= EVAL_I;
                    end
                end
                EVAL_I: begin
                    if (!gate_q && lazy_q) begin
                        rd_valid_q <= 1'b1;
                        rd_data_q  <= '0;
                        rd_pos_q   <= pos_q;
                        rd_err_q   <= 1'b0;
                        state_q    <= OUT;
                    end else begin
                        pos_q   <= pos_d;
                        idx_i_q <= idx_d;
                        err_q   <= oor;
                        state_q <= EVAL_J;
                    end
                end
                EVAL_J: begin
                    pos_q   <= pos_d;
                    idx_j_q <= idx_d;
                    err_q   <= err_q | oor;
                    state_q <= EVAL_K;
                end
                EVAL_K: begin
                    pos_q   <= pos_d;
                    idx_k_q <= idx_d;
                    err_q   <= err_q | oor;
                    state_q <= READ;
                end
                READ: begin
                    rd_valid_q <= 1'b1;
                    rd_data_q  <= (err_q || !gate_q) ? '0 : tbl[rd_addr];
                    rd_pos_q   <= pos_q;
                    rd_err_q   <= err_q;
                    state_q    <= OUT;
                end
                OUT: begin
                    if (bus.rd_ready) begin
                        rd_valid_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign bus.cmd_ready = state_q == IDLE;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_pos    = rd_pos_q;
    assign bus.rd_err    = rd_err_q;
endmodule

// File: tb/tb_idx_step_reader.sv
// tb_idx_step_reader: directed vector table plus hand sequences for hold, read-first and mid-op reset.
module tb_idx_step_reader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    idx_step_reader_if #(.DW(32), .PW(8), .AW(5)) bus();
    idx_step_reader dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    int checks = 0;
    int errors = 0;
    typedef struct {
        logic        ld;
        logic [7:0]  pv;
        logic [2:0]  oi, oj, ok;
        logic        g, l;
        logic [31:0] ed;
        logic [7:0]  ep;
        logic        ee;
        int          el;
    } vec_t;
    vec_t vt[11];
    vec_t v;
    int lat;
    bit seen;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    task automatic issue(input vec_t c);
        @(negedge clk);
        bus.pos_load     = c.ld;
        bus.pos_load_val = c.pv;
        bus.cmd_op_i     = c.oi;
        bus.cmd_op_j     = c.oj;
        bus.cmd_op_k     = c.ok;
        bus.cmd_gate     = c.g;
        bus.cmd_lazy     = c.l;
        bus.cmd_valid    = 1'b1;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.pos_load  = 1'b0;
    endtask
    task automatic wait_valid(output int n);
        n = 0;
        while (!bus.rd_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask
    task automatic handshake();
        bus.rd_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rd_ready = 1'b0;
    endtask
    task automatic run(input vec_t c, input string nm);
        int n;
        issue(c);
        wait_valid(n);
        chk({nm, " latency"}, n, c.el);
        chk({nm, " rd_data"}, bus.rd_data, c.ed);
        chk({nm, " rd_pos"}, 32'(bus.rd_pos), 32'(c.ep));
        chk({nm, " rd_err"}, 32'(bus.rd_err), 32'(c.ee));
        handshake();
        chk({nm, " idle ready"}, 32'({bus.cmd_ready, bus.rd_valid}), 32'b10);
    endtask
    initial begin
        bus.cmd_valid = 0; bus.cmd_op_i = 0; bus.cmd_op_j = 0; bus.cmd_op_k = 0;
        bus.cmd_gate = 0; bus.cmd_lazy = 0; bus.pos_load = 0; bus.pos_load_val = 0;
        bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0; bus.rd_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset rd_valid", 32'(bus.rd_valid), 0);
        chk("reset rd_data", bus.rd_data, 0);
        chk("reset rd_pos", 32'(bus.rd_pos), 0);
        chk("reset rd_err", 32'(bus.rd_err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset cmd_ready", 32'(bus.cmd_ready), 1);
        //         ld  pv    oi oj ok g  l  data   pos  err lat
        vt[0]  = '{1, 8'd0,   1, 1, 2, 1, 1, 32'd7,  8'd3,   0, 4};
        vt[1]  = '{1, 8'd1,   3, 2, 2, 1, 1, 32'd18, 8'd2,   0, 4};
        vt[2]  = '{1, 8'd0,   2, 2, 2, 0, 1, 32'd0,  8'd0,   0, 1};
        vt[3]  = '{1, 8'd0,   2, 2, 2, 0, 0, 32'd0,  8'd3,   0, 4};
        vt[4]  = '{1, 8'd0,   4, 0, 0, 1, 1, 32'd0,  8'd255, 1, 4};
        vt[5]  = '{1, 8'd5,   0, 0, 0, 1, 1, 32'd0,  8'd5,   1, 4};
        vt[6]  = '{1, 8'd0,   2, 2, 2, 1, 0, 32'd23, 8'd3,   0, 4};
        vt[7]  = '{1, 8'd254, 2, 2, 2, 1, 1, 32'd0,  8'd1,   1, 4};
        vt[8]  = '{1, 8'd1,   7, 6, 5, 1, 1, 32'd17, 8'd1,   0, 4};
        vt[9]  = '{1, 8'd2,   3, 1, 3, 1, 1, 32'd0,  8'd1,   1, 4};
        vt[10] = '{1, 8'd200, 4, 4, 4, 0, 1, 32'd0,  8'd200, 0, 1};
        for (int i = 0; i < 11; i++) run(vt[i], $sformatf("vec%0d", i));
        @(negedge clk);
        bus.wr_en = 1; bus.wr_addr = 5'd7; bus.wr_data = 32'hDEADBEEF;
        @(negedge clk);
        bus.wr_en = 0;
        issue(vt[0]);
        repeat (3) @(posedge clk);
        #1;
        chk("hold pre-valid", 32'(bus.rd_valid), 0);
        bus.wr_en = 1; bus.wr_addr = 5'd7; bus.wr_data = 32'h12345678;
        @(posedge clk);
        #1;
        bus.wr_en = 0;
        chk("hold valid edge4", 32'(bus.rd_valid), 1);
        chk("read-first data", bus.rd_data, 32'hDEADBEEF);
        bus.pos_load = 1; bus.pos_load_val = 8'd99;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("hold%0d state", i), 32'({bus.rd_valid, bus.cmd_ready}), 32'b10);
            chk($sformatf("hold%0d data", i), bus.rd_data, 32'hDEADBEEF);
        end
        bus.pos_load = 0;
        chk("hold rd_pos", 32'(bus.rd_pos), 3);
        handshake();
        chk("hold released", 32'(bus.cmd_ready), 1);
        v = '{0, 8'd0, 0, 0, 0, 1, 1, 32'd0, 8'd3, 1, 4};
        run(v, "load ignored");
        v = '{1, 8'd0, 1, 1, 2, 1, 1, 32'h12345678, 8'd3, 0, 4};
        run(v, "after write");
        v = '{1, 8'd0, 1, 1, 2, 1, 1, 32'd0, 8'd0, 0, 0};
        issue(v);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst rd_valid", 32'(bus.rd_valid), 0);
        chk("midrst rd_data", bus.rd_data, 0);
        chk("midrst rd_pos", 32'(bus.rd_pos), 0);
        chk("midrst rd_err", 32'(bus.rd_err), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (bus.rd_valid) seen = 1;
        end
        chk("midrst no response", 32'(seen), 0);
        v = '{0, 8'd0, 1, 1, 2, 1, 1, 32'h12345678, 8'd3, 0, 4};
        run(v, "post reset");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
